// File: rtl/bsg_ss_tline_pkg.sv
// Shared types and constants for the source-synchronous tline transmitter.
// Holds the FSM encoding, the calibration byte pattern and credit-width helper.
package bsg_ss_tline_pkg;

    typedef enum logic [1:0] {
        eRESET,
        eCALIB,
        eRUN
    } state_e;

    localparam logic [7:0] calib_even_c = 8'hAA;
    localparam logic [7:0] calib_odd_c  = 8'h55;

    function automatic int credit_width(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/bsg_ss_tline_credit_counter.sv
// Credit meter: detects returned token toggles, adds/subtracts credits and
// saturates at the receiver FIFO depth with a sticky overflow flag.
module bsg_ss_tline_credit_counter
    import bsg_ss_tline_pkg::*;
#(
    parameter int max_credits_p       = 16,
    parameter int credit_decimation_p = 4,
    localparam int credit_w_lp        = credit_width(max_credits_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   load_i,
    input  logic                   send_i,
    input  logic                   token_toggle_i,
    output logic [credit_w_lp-1:0] credits_o,
    output logic                   overflow_o
);

    // One extra bit so credits + decimation cannot wrap before the compare.
    localparam int sum_w_lp = credit_w_lp + 1;
    localparam logic [sum_w_lp-1:0] max_ext_lp = sum_w_lp'(max_credits_p);

    logic                token_r;
    logic                token_edge;
    logic                send_ok;
    logic [sum_w_lp-1:0] sum;

    function automatic logic [credit_w_lp-1:0] saturate(input logic [sum_w_lp-1:0] value);
        return (value > max_ext_lp) ? credit_w_lp'(max_credits_p) : value[credit_w_lp-1:0];
    endfunction

    assign token_edge = token_toggle_i ^ token_r;
    assign send_ok    = send_i & (credits_o != '0);
    assign sum        = sum_w_lp'(credits_o)
                      + (token_edge ? sum_w_lp'(credit_decimation_p) : '0)
                      - sum_w_lp'(send_ok);

    always_ff @(posedge clk_i) begin
        token_r <= token_toggle_i;
        if (!reset_n_i) begin
            credits_o  <= '0;
            overflow_o <= 1'b0;
        end else if (load_i) begin
            credits_o <= credit_w_lp'(max_credits_p);
        end else begin
            credits_o  <= saturate(sum);
            overflow_o <= overflow_o | (sum > max_ext_lp);
        end
    end

endmodule

// File: rtl/bsg_ss_tline_tx.sv
// Single-channel tline transmitter: forwards clock/valid/data, runs a fixed
// AA/55 calibration after reset, then streams core words under credit control.
module bsg_ss_tline_tx
    import bsg_ss_tline_pkg::*;
#(
    parameter int channel_width_p     = 8,
    parameter int max_credits_p       = 16,
    parameter int credit_decimation_p = 4,
    parameter int calib_cycles_p      = 64,
    localparam int credit_w_lp        = credit_width(max_credits_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [channel_width_p-1:0] data_i,
    output logic                       ready_o,
    input  logic                       token_toggle_i,
    output logic                       tline_clk_o,
    output logic                       tline_valid_o,
    output logic [channel_width_p-1:0] tline_data_o,
    output logic [credit_w_lp-1:0]     credits_o,
    output logic                       calib_done_o,
    output logic                       overflow_o
);

    localparam int cnt_w_lp = (calib_cycles_p > 1) ? $clog2(calib_cycles_p) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(calib_cycles_p - 1);

    state_e                     state_r, state_n;
    logic [cnt_w_lp-1:0]        cnt_r, cnt_n;
    logic                       valid_n;
    logic [channel_width_p-1:0] data_n;
    logic                       send;
    logic                       load;
    logic                       counter_reset_n;

    function automatic logic [channel_width_p-1:0] calib_word(input logic odd);
        logic [7:0]                 pat;
        logic [channel_width_p-1:0] w;
        pat = odd ? calib_odd_c : calib_even_c;
        for (int i = 0; i < channel_width_p; i++) begin
            w[i] = pat[3'(i % 8)];
        end
        return w;
    endfunction

    assign ready_o      = (credits_o != '0);
    assign send         = v_i & ready_o;
    assign calib_done_o = (state_r == eRUN);

    // Holding the meter in reset outside eRUN makes calibration ignore tokens
    // while its edge register keeps tracking the toggle line.
    assign counter_reset_n = reset_n_i & ((state_r == eRUN) | load);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r       <= eRESET;
            cnt_r         <= '0;
            tline_clk_o   <= 1'b0;
            tline_valid_o <= 1'b0;
            tline_data_o  <= '0;
        end else begin
            state_r       <= state_n;
            cnt_r         <= cnt_n;
            tline_clk_o   <= ~tline_clk_o;
            tline_valid_o <= valid_n;
            tline_data_o  <= data_n;
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        valid_n = 1'b0;
        data_n  = tline_data_o;
        load    = 1'b0;
        case (state_r)
            eRESET: begin
                state_n = eCALIB;
                cnt_n   = '0;
                data_n  = calib_word(1'b0);
            end
            eCALIB: begin
                if (cnt_r == cnt_last_lp) begin
                    state_n = eRUN;
                    load    = 1'b1;
                end else begin
                    cnt_n  = cnt_r + 1'b1;
                    data_n = calib_word(~cnt_r[0]);
                end
            end
            eRUN: begin
                if (send) begin
                    valid_n = 1'b1;
                    data_n  = data_i;
                end
            end
            default: state_n = eRESET;
        endcase
    end

    bsg_ss_tline_credit_counter #(
        .max_credits_p      (max_credits_p),
        .credit_decimation_p(credit_decimation_p)
    ) credit_counter (
        .clk_i         (clk_i),
        .reset_n_i     (counter_reset_n),
        .load_i        (load),
        .send_i        (send),
        .token_toggle_i(token_toggle_i),
        .credits_o     (credits_o),
        .overflow_o    (overflow_o)
    );

endmodule

// File: tb/tb_bsg_ss_tline_tx.sv
// Directed self-checking bench for bsg_ss_tline_tx with default parameters.
module tb_bsg_ss_tline_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       v;
    logic [7:0] data;
    logic       ready;
    logic       token;
    logic       tline_clk;
    logic       tline_valid;
    logic [7:0] tline_data;
    logic [4:0] credits;
    logic       calib_done;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    bsg_ss_tline_tx dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .v_i           (v),
        .data_i        (data),
        .ready_o       (ready),
        .token_toggle_i(token),
        .tline_clk_o   (tline_clk),
        .tline_valid_o (tline_valid),
        .tline_data_o  (tline_data),
        .credits_o     (credits),
        .calib_done_o  (calib_done),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tclk"},  32'(tline_clk),   0);
        check({tag, "_valid"}, 32'(tline_valid), 0);
        check({tag, "_data"},  32'(tline_data),  0);
        check({tag, "_ready"}, 32'(ready),       0);
        check({tag, "_cred"},  32'(credits),     0);
        check({tag, "_done"},  32'(calib_done),  0);
        check({tag, "_ovf"},   32'(overflow),    0);
    endtask

    task automatic run_calib(input string tag, input logic toggle_tokens);
        for (int k = 1; k <= 64; k++) begin
            if (toggle_tokens && (k % 10 == 0) && k <= 50) token = ~token;
            tick();
            check({tag, "_data"},  32'(tline_data),  (k % 2 == 1) ? 32'hAA : 32'h55);
            check({tag, "_tclk"},  32'(tline_clk),   32'(k % 2));
            check({tag, "_valid"}, 32'(tline_valid), 0);
            check({tag, "_ready"}, 32'(ready),       0);
            check({tag, "_cred"},  32'(credits),     0);
            check({tag, "_done"},  32'(calib_done),  0);
        end
        check({tag, "_ovf"}, 32'(overflow), 0);
        tick();
        check({tag, "_done65"}, 32'(calib_done), 1);
        check({tag, "_cred65"}, 32'(credits),    16);
        check({tag, "_rdy65"},  32'(ready),      1);
        check({tag, "_hold65"}, 32'(tline_data), 32'h55);
    endtask

    initial begin
        reset_n = 1'b0;
        v       = 1'b0;
        data    = 8'h00;
        token   = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");

        // Calibration with five token toggles that must be ignored.
        reset_n = 1'b1;
        run_calib("cal", 1'b1);

        // Stream 16 words with no tokens: full credit drain.
        for (int w = 1; w <= 16; w++) begin
            v    = 1'b1;
            data = 8'(w);
            tick();
            check("drain_valid", 32'(tline_valid), 1);
            check("drain_data",  32'(tline_data),  32'(w));
            check("drain_cred",  32'(credits),     32'(16 - w));
        end
        data = 8'd17;
        check("empty_ready", 32'(ready), 0);
        tick();
        check("stall_valid", 32'(tline_valid), 0);
        check("stall_data",  32'(tline_data),  16);
        check("stall_cred",  32'(credits),     0);

        // One token edge at zero credits refills four.
        token = ~token;
        tick();
        check("refill_cred",  32'(credits),     4);
        check("refill_valid", 32'(tline_valid), 0);
        for (int j = 0; j < 4; j++) begin
            data = 8'(17 + j);
            tick();
            check("refill_send_valid", 32'(tline_valid), 1);
            check("refill_send_data",  32'(tline_data),  32'(17 + j));
            check("refill_send_cred",  32'(credits),     32'(3 - j));
        end
        data = 8'd21;
        tick();
        check("refill_stall_valid", 32'(tline_valid), 0);
        check("refill_stall_cred",  32'(credits),     0);
        check("refill_stall_data",  32'(tline_data),  20);

        // Send and token edge in the same cycle at three credits.
        v     = 1'b0;
        token = ~token;
        tick();
        check("both_pre_cred", 32'(credits), 4);
        v    = 1'b1;
        data = 8'h30;
        tick();
        check("both_pre_send", 32'(credits), 3);
        token = ~token;
        data  = 8'h31;
        tick();
        check("both_cred",  32'(credits),     6);
        check("both_valid", 32'(tline_valid), 1);
        check("both_data",  32'(tline_data),  32'h31);

        // Reach nine credits mid-stream, then a one-cycle reset.
        v     = 1'b0;
        token = ~token;
        tick();
        check("mid_cred10", 32'(credits), 10);
        v    = 1'b1;
        data = 8'h40;
        tick();
        check("mid_cred9", 32'(credits),  9);
        check("mid_ovf",   32'(overflow), 0);
        data    = 8'h41;
        reset_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        v       = 1'b0;
        run_calib("recal", 1'b0);

        // Token edge at full credits saturates and latches overflow.
        token = ~token;
        tick();
        check("sat_cred", 32'(credits),  16);
        check("sat_ovf",  32'(overflow), 1);
        v    = 1'b1;
        data = 8'h50;
        tick();
        check("sat_send_cred",  32'(credits),     15);
        check("sat_send_valid", 32'(tline_valid), 1);
        check("sat_send_ovf",   32'(overflow),    1);
        v = 1'b0;
        tick();
        tick();
        tick();
        check("sat_sticky_ovf", 32'(overflow), 1);
        reset_n = 1'b0;
        tick();
        check("final_rst_ovf",  32'(overflow), 0);
        check("final_rst_cred", 32'(credits),  0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
